prod_byte_serializer: RTL and testbench
=======================================

Name: prod_byte_serializer

Overview:
- Downstream stage of the radix-4 signed multiplier datapath.
- Captures each completed product word on the controller's done pulse and buffers it in a small FIFO.
- Streams each product out as bytes over a valid/ready interface toward the board UART/display driver.
- The multiplier cannot be stalled mid-operation, so this block absorbs bursts and flags any product that arrives while it is full.

Parameters:
PW, 32, product width in bits; must be a multiple of BW.
BW, 8, output byte width in bits.
DEPTH, 2, product FIFO depth in words; power of two, >= 2.
MSB_FIRST, 1, 1 = most significant byte first; 0 = least significant byte first.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
prod_valid  in  1  one-cycle pulse: prod holds a finished product.
prod  in  PW  signed product word (multiplier output).
prod_ready  out  1  FIFO not full; the controller gates its next start on this.
out_valid  out  1  out_data holds a valid byte.
out_data  out  BW  current byte.
out_last  out  1  high with the final byte of a product.
out_ready  in  1  consumer accepts the byte this cycle.
drop  out  1  sticky: a product was discarded because the FIFO was full.
clr_drop  in  1  synchronous clear of drop.
level  out  $clog2(DEPTH)+1  number of words in the FIFO.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, level=0, state IDLE, out_valid=0, out_data=0, out_last=0, drop=0, prod_ready=1. Applies immediately, including mid-product; the partially sent word is lost.
- Push: on each edge where prod_valid=1 and the FIFO is not full (evaluated before any same-cycle pop), prod is written.
- Push while full: discarded even if a pop occurs in the same cycle; drop is set to 1.
- prod_ready = !full, combinational from the registered level.
- drop: set by a discarded push; cleared by clr_drop. If both occur in the same cycle, set wins.
- Byte handshake: a byte transfers on an edge with out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- Serializer FSM, states IDLE and SEND; byte counter idx runs 0..PW/BW-1.
  - IDLE: if FIFO non-empty, pop head into the shift register, idx=0, go to SEND. out_valid=1 from the next cycle.
  - SEND:
    - Each transfer advances idx and shifts the register by BW toward the output end.
    - out_last = (idx == PW/BW-1).
    - On the transfer of the last byte with the FIFO non-empty, pop the next word directly with no bubble cycle and stay in SEND.
    - On the transfer of the last byte with the FIFO empty, go to IDLE and set out_valid=0.
- Latency: a push into an empty FIFO while IDLE gives its first byte on out_valid two edges after the push edge.
- Sustained throughput: one byte per cycle with out_ready held high.
- Byte order:
  - MSB_FIRST=1: byte 0 = prod[PW-1 -: BW].
  - MSB_FIRST=0: byte 0 = prod[BW-1:0].
  - No sign handling; bytes are raw two's-complement slices.
- level:
  - +1 on a push alone, -1 on a pop alone, unchanged when both occur.
  - Never exceeds DEPTH; pointers wrap modulo DEPTH.

Optional Feature:
- Macro: BYTE_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR reduction) of out_data.
  - Valid whenever out_valid=1 and held stable under backpressure with out_data.
- Undefined:
  - The port does not exist and no parity logic is generated.
  - All other behaviour is identical.

Decomposition:
- Shared package prod_ser_pkg:
  - default constants PW_DEF=32, BW_DEF=8;
  - typedef enum ser_state_t {S_IDLE, S_SEND};
  - function nbytes(PW, BW).
- Sub-module prod_fifo:
  - parameterised width/depth synchronous FIFO;
  - ports for push, pop, din, dout, full, empty, level;
  - same clk/rst convention.
- The serializer FSM and shift register stay in the top module.

Test Plan:
1. Push 0x12345678 with out_ready=1 → out_data 12,34,56,78 on four consecutive cycles, out_last only on 78, first byte two edges after the push.
2. Push 0xFFFFFF9C (-100 from the multiplier) with out_ready toggling 1,0,0,1,... → bytes FF,FF,FF,9C, each held stable while out_ready=0.
3. Hold out_ready=0, pulse prod_valid three times (0x11111111, 0x22222222, 0x33333333), DEPTH=2:
   - after the serializer pops 0x11111111 into SEND, the third push makes level=2 and prod_ready=0;
   - then a fourth push 0x44444444 is dropped and drop=1;
   - releasing out_ready yields 11×4, 22×4, 33×4 back-to-back with no bubble, then drop clears on clr_drop.
4. Assert rst low after the second byte of 0xA1B2C3D4 → all outputs return to reset values asynchronously; after release, a new push 0x00000001 streams 00,00,00,01.
5. MSB_FIRST=0, push 0x12345678 → 78,56,34,12.
6. BYTE_PARITY_EN defined, push 0x01030700 → out_parity 1,0,1,0 on bytes 01,03,07,00.

Source files
------------

// File: rtl/prod_byte_serializer_pkg.sv
// Shared constants, state type and helpers for the product byte serializer.
// Used by prod_fifo and prod_byte_serializer.
package prod_ser_pkg;

  localparam int PW_DEF = 32;
  localparam int BW_DEF = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

  function automatic int nbytes(input int pw, input int bw);
    return pw / bw;
  endfunction

endpackage

// File: rtl/prod_byte_serializer_fifo.sv
// Product word FIFO for the serializer: push-before-pop full check,
// registered level, pointers wrap modulo DEPTH (power of two).
module prod_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/prod_byte_serializer.sv
// Buffers multiplier products and streams them out as bytes (valid/ready).
// Optional BYTE_PARITY_EN adds out_parity = XOR of out_data.
module prod_byte_serializer
  import prod_ser_pkg::*;
#(
  parameter int PW        = PW_DEF,
  parameter int BW        = BW_DEF,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prod_valid,
  input  logic [PW-1:0]          prod,
  output logic                   prod_ready,
  output logic                   out_valid,
  output logic [BW-1:0]          out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   drop,
  input  logic                   clr_drop,
`ifdef BYTE_PARITY_EN
  output logic                   out_parity,
`endif
  output logic [$clog2(DEPTH):0] level
);

  localparam int NB = nbytes(PW, BW);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  ser_state_t    state_q;
  ser_state_t    state_d;
  logic [PW-1:0] sh_q;
  logic [PW-1:0] sh_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          fifo_pop;
  logic [PW-1:0] fifo_dout;
  logic          full;
  logic          empty;
  logic          xfer;

  prod_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (prod_valid),
    .pop   (fifo_pop),
    .din   (prod),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign prod_ready = ~full;
  assign out_valid  = (state_q == S_SEND);
  assign out_last   = out_valid & (idx_q == LAST);
  assign xfer       = out_valid & out_ready;

  if (MSB_FIRST != 0) begin : g_msb
    assign out_data = sh_q[PW-1 -: BW];
  end else begin : g_lsb
    assign out_data = sh_q[BW-1:0];
  end

`ifdef BYTE_PARITY_EN
  assign out_parity = ^out_data;
`endif

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          idx_d    = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (idx_q == LAST) begin
            // back-to-back words: reload without a bubble
            if (!empty) begin
              fifo_pop = 1'b1;
              sh_d     = fifo_dout;
              idx_d    = '0;
            end else begin
              sh_d    = '0;
              idx_d   = '0;
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            if (MSB_FIRST != 0) begin
              sh_d = sh_q << BW;
            end else begin
              sh_d = sh_q >> BW;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
    end
  end

  // a discarded push outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop <= 1'b0;
    end else if (prod_valid && full) begin
      drop <= 1'b1;
    end else if (clr_drop) begin
      drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prod_byte_serializer.sv
// Directed self-checking bench for prod_byte_serializer (MSB and LSB order).
// Parity checks are included when BYTE_PARITY_EN is defined.
module tb_prod_byte_serializer;

  logic        clk;
  logic        rst;
  logic        prod_valid;
  logic [31:0] prod;
  logic        prod_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        drop;
  logic        clr_drop;
  logic [1:0]  level;

  logic        pv2;
  logic [31:0] prod2;
  logic        prdy2;
  logic        ov2;
  logic [7:0]  od2;
  logic        ol2;
  logic        drop2;
  logic [1:0]  lvl2;

`ifdef BYTE_PARITY_EN
  logic        out_parity;
  logic        par2;
`endif

  int total;
  int fails;

  prod_byte_serializer #(
    .PW(32), .BW(8), .DEPTH(2), .MSB_FIRST(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .drop       (drop),
    .clr_drop   (clr_drop),
`ifdef BYTE_PARITY_EN
    .out_parity (out_parity),
`endif
    .level      (level)
  );

  prod_byte_serializer #(
    .PW(32), .BW(8), .DEPTH(2), .MSB_FIRST(0)
  ) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (pv2),
    .prod       (prod2),
    .prod_ready (prdy2),
    .out_valid  (ov2),
    .out_data   (od2),
    .out_last   (ol2),
    .out_ready  (1'b1),
    .drop       (drop2),
    .clr_drop   (1'b0),
`ifdef BYTE_PARITY_EN
    .out_parity (par2),
`endif
    .level      (lvl2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] d,
                          input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_last"}, 32'(out_last), 32'(l));
  endtask

  logic [7:0] w3 [3];

  initial begin
    total      = 0;
    fails      = 0;
    rst        = 1'b0;
    prod_valid = 1'b0;
    prod       = '0;
    out_ready  = 1'b0;
    clr_drop   = 1'b0;
    pv2        = 1'b0;
    prod2      = '0;
    w3[0] = 8'h11;
    w3[1] = 8'h22;
    w3[2] = 8'h33;

    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(prod_ready), 32'd1);
    chk("rst_drop", 32'(drop), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // 1: plain stream, two-edge latency
    prod_valid = 1'b1;
    prod       = 32'h12345678;
    out_ready  = 1'b1;
    step();
    prod_valid = 1'b0;
    chk("t1_lat_valid", 32'(out_valid), 32'd0);
    chk("t1_lat_level", 32'(level), 32'd1);
    step();
    chk_byte("t1_b0", 8'h12, 1'b0);
    chk("t1_level0", 32'(level), 32'd0);
    step();
    chk_byte("t1_b1", 8'h34, 1'b0);
    step();
    chk_byte("t1_b2", 8'h56, 1'b0);
    step();
    chk_byte("t1_b3", 8'h78, 1'b1);
    step();
    chk("t1_idle", 32'(out_valid), 32'd0);

    // 2: backpressure 1,0,0,1,...
    prod_valid = 1'b1;
    prod       = 32'hFFFFFF9C;
    out_ready  = 1'b0;
    step();
    prod_valid = 1'b0;
    step();
    chk_byte("t2_b0", 8'hFF, 1'b0);
    out_ready = 1'b1;
    step();
    chk_byte("t2_b1", 8'hFF, 1'b0);
    out_ready = 1'b0;
    step();
    chk_byte("t2_b1h", 8'hFF, 1'b0);
    step();
    chk_byte("t2_b1h2", 8'hFF, 1'b0);
    out_ready = 1'b1;
    step();
    chk_byte("t2_b2", 8'hFF, 1'b0);
    out_ready = 1'b0;
    step();
    chk_byte("t2_b2h", 8'hFF, 1'b0);
    out_ready = 1'b1;
    step();
    chk_byte("t2_b3", 8'h9C, 1'b1);
    out_ready = 1'b0;
    step();
    chk_byte("t2_b3h", 8'h9C, 1'b1);
    step();
    chk_byte("t2_b3h2", 8'h9C, 1'b1);
    out_ready = 1'b1;
    step();
    chk("t2_idle", 32'(out_valid), 32'd0);

    // 3: fill, overflow, drain without bubbles
    out_ready  = 1'b0;
    prod_valid = 1'b1;
    prod       = 32'h11111111;
    step();
    chk("t3_lvl1", 32'(level), 32'd1);
    prod = 32'h22222222;
    step();
    chk("t3_lvl_pp", 32'(level), 32'd1);
    chk_byte("t3_head", 8'h11, 1'b0);
    prod = 32'h33333333;
    step();
    chk("t3_lvl_full", 32'(level), 32'd2);
    chk("t3_nready", 32'(prod_ready), 32'd0);
    chk("t3_nodrop", 32'(drop), 32'd0);
    prod = 32'h44444444;
    step();
    prod_valid = 1'b0;
    chk("t3_drop", 32'(drop), 32'd1);
    chk("t3_lvl_keep", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk_byte($sformatf("t3_s%0d", i), w3[i / 4], (i % 4) == 3);
      step();
    end
    chk("t3_idle", 32'(out_valid), 32'd0);
    chk("t3_lvl_end", 32'(level), 32'd0);
    chk("t3_drop_held", 32'(drop), 32'd1);
    clr_drop = 1'b1;
    step();
    clr_drop = 1'b0;
    chk("t3_drop_clr", 32'(drop), 32'd0);

    // 4: asynchronous reset mid-product
    prod_valid = 1'b1;
    prod       = 32'hA1B2C3D4;
    step();
    prod_valid = 1'b0;
    step();
    chk_byte("t4_b0", 8'hA1, 1'b0);
    step();
    chk_byte("t4_b1", 8'hB2, 1'b0);
    step();
    chk_byte("t4_b2", 8'hC3, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    chk("t4_rst_data", 32'(out_data), 32'd0);
    chk("t4_rst_last", 32'(out_last), 32'd0);
    chk("t4_rst_level", 32'(level), 32'd0);
    chk("t4_rst_ready", 32'(prod_ready), 32'd1);
    @(negedge clk);
    rst        = 1'b1;
    prod_valid = 1'b1;
    prod       = 32'h00000001;
    step();
    prod_valid = 1'b0;
    chk("t4_lat", 32'(out_valid), 32'd0);
    step();
    chk_byte("t4_n0", 8'h00, 1'b0);
    step();
    chk_byte("t4_n1", 8'h00, 1'b0);
    step();
    chk_byte("t4_n2", 8'h00, 1'b0);
    step();
    chk_byte("t4_n3", 8'h01, 1'b1);
    step();
    chk("t4_idle", 32'(out_valid), 32'd0);

    // 5: LSB-first instance
    pv2   = 1'b1;
    prod2 = 32'h12345678;
    step();
    pv2 = 1'b0;
    chk("t5_lat", 32'(ov2), 32'd0);
    step();
    chk("t5_b0", {22'd0, ov2, ol2, od2}, {22'd0, 2'b10, 8'h78});
    step();
    chk("t5_b1", {22'd0, ov2, ol2, od2}, {22'd0, 2'b10, 8'h56});
    step();
    chk("t5_b2", {22'd0, ov2, ol2, od2}, {22'd0, 2'b10, 8'h34});
    step();
    chk("t5_b3", {22'd0, ov2, ol2, od2}, {22'd0, 2'b11, 8'h12});
    step();
    chk("t5_idle", 32'(ov2), 32'd0);

`ifdef BYTE_PARITY_EN
    // 6: even parity per byte, held under backpressure
    prod_valid = 1'b1;
    prod       = 32'h01030700;
    out_ready  = 1'b0;
    step();
    prod_valid = 1'b0;
    step();
    chk_byte("t6_b0", 8'h01, 1'b0);
    chk("t6_p0", 32'(out_parity), 32'd1);
    step();
    chk("t6_p0h", 32'(out_parity), 32'd1);
    out_ready = 1'b1;
    step();
    chk_byte("t6_b1", 8'h03, 1'b0);
    chk("t6_p1", 32'(out_parity), 32'd0);
    step();
    chk_byte("t6_b2", 8'h07, 1'b0);
    chk("t6_p2", 32'(out_parity), 32'd1);
    step();
    chk_byte("t6_b3", 8'h00, 1'b1);
    chk("t6_p3", 32'(out_parity), 32'd0);
    step();
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
